traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Demand-driven phase controller for a 4-approach intersection; extends the fixed main/side light cycle to sensor-actuated service.
//  Latches per-approach vehicle requests, grants green round-robin, enforces min/max green, yellow and all-red clearance.
//  Its registered lamp outputs drive the signal heads directly; the timebase arrives as a 1-cycle tick enable.
// PARAMETERS
//  MIN_GREEN  10  ticks of green guaranteed before any switch
//  MAX_GREEN  40  ticks of green after which conflicting demand forces a switch
//  YELLOW_T   5   ticks of yellow
//  ALL_RED_T  2   ticks of all-red clearance after every yellow
//  WALK_T     8   ticks of pedestrian walk (used only with PED_PHASE_EN)
//  CNT_W      7   phase timer width; MAX_GREEN, YELLOW_T, ALL_RED_T, WALK_T < 2**CNT_W
// PORTS
//  clk        in   1  system clock
//  rst        in   1  reset, synchronous, active-low
//  tick       in   1  timebase enable; timers advance only when high
//  req        in   4  vehicle detector per approach, level, bit i = approach i
//  green      out  4  green lamp per approach
//  yellow     out  4  yellow lamp per approach
//  red        out  4  red lamp per approach (= ~(green|yellow))
//  cur_app    out  2  approach holding / last holding right-of-way
//  phase      out  3  current phase_e encoding
// BEHAVIOUR
//  Reset (rst=0 at posedge): phase=IDLE, red=4'hF, green=yellow=0, cur_app=0, timer=0, pending=0.
//   Reset mid-phase: all-red on next cycle, pending cleared, no yellow run-out.
//  pending[i] set on any cycle req[i]=1, except i=cur_app while phase=GREEN; cleared on entry to GREEN for i.
//  Phases (one-hot lamp invariant: at most one bit of green|yellow set):
//   IDLE:    all red; if pending!=0 -> GREEN on next cycle, approach = rr pick starting at cur_app+1 (mod 4).
//   GREEN:   timer counts ticks from 0. other = pending & ~(1<<cur_app).
//            -> YELLOW when timer>=MIN_GREEN and other!=0 and (req[cur_app]=0 (gap-out) or timer==MAX_GREEN (max-out)).
//            other==0: rest in green indefinitely, timer saturates at MAX_GREEN.
//   YELLOW:  YELLOW_T ticks -> ALL_RED.
//   ALL_RED: ALL_RED_T ticks -> GREEN on rr pick if pending!=0, else IDLE.
//  Timer resets to 0 on every phase entry; transition evaluated on the tick cycle, lamps update on following edge (1-cycle latency).
//  Simultaneous requests: served in round-robin order after cur_app; no approach starves (max 3 intervening greens).
//  tick and req in same cycle: both take effect; tick=0 freezes timers but requests still latch.
// CONFIGURATION
//  PED_PHASE_EN defined:
//   extra ports: ped_req in 1 (pulse, latched to ped_pend), walk out 1.
//   ALL_RED exit: ped_pend=1 has priority -> WALK (all red, walk=1, WALK_T ticks) -> ALL_RED -> vehicle pick.
//   ped_pend cleared on WALK entry; reset value walk=0, ped_pend=0.
//  PED_PHASE_EN undefined: no ped ports, WALK state unreachable, walk logic absent.
// STRUCTURE
//  Package traffic_pkg: typedef enum phase_e {IDLE, GREEN, YELLOW, ALL_RED, WALK}; N_APP=4; APP_W=2.
//  Sub-module rr_picker: combinational round-robin select (pending[3:0], last[1:0]) -> valid, grant[1:0].
//  Top holds FSM, phase timer, pending/ped_pend registers and registered lamp outputs.
// TESTING (MIN_GREEN=3, MAX_GREEN=6, YELLOW_T=2, ALL_RED_T=1, tick=1 every cycle)
//  1 rst=0 2 cycles, then rst=0 again mid-YELLOW -> red=4'hF, green=0, yellow=0, phase=IDLE, pending=0 next cycle.
//  2 IDLE, req=4'b0010 one cycle -> green=4'b0010, cur_app=1; no other demand -> green held 50+ cycles.
//  3 green on 1, req[1] held, req[3] pulsed -> max-out: yellow=4'b0010 after 6 ticks, 2 ticks yellow, 1 all-red, green=4'b1000.
//  4 green on 1, req[1] drops at tick 1, req[2] pending -> gap-out: yellow at tick 3 (MIN_GREEN), never earlier.
//  5 IDLE, cur_app=0, req=4'b1111 held -> green order 1,2,3,0,1; each max-out at 6 ticks; lamp invariant holds.
//  6 PED_PHASE_EN: ped_req pulse during green on 0 with req[2] pending -> after all-red, walk=1 8 ticks, all-red, green=4'b0100.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase scheduler: phase encoding, approach count/width, lamp one-hot helper.
package traffic_pkg;

  localparam int N_APP = 4;
  localparam int APP_W = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    ALL_RED = 3'd3,
    WALK    = 3'd4
  } phase_e;

  function automatic logic [N_APP-1:0] app_onehot(input logic [APP_W-1:0] a);
    app_onehot    = '0;
    app_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Detector/timebase inputs and lamp outputs of the phase scheduler; slave = scheduler side.
// PED_PHASE_EN adds ped_req/walk.
interface traffic_phase_scheduler_if;
  import traffic_pkg::*;

  logic             tick;
  logic [N_APP-1:0] req;
  logic [N_APP-1:0] green;
  logic [N_APP-1:0] yellow;
  logic [N_APP-1:0] red;
  logic [APP_W-1:0] cur_app;
  phase_e           phase;

`ifdef PED_PHASE_EN
  logic ped_req;
  logic walk;

  modport slave  (input  tick, req, ped_req, output green, yellow, red, cur_app, phase, walk);
  modport master (output tick, req, ped_req, input  green, yellow, red, cur_app, phase, walk);
`else
  modport slave  (input  tick, req, output green, yellow, red, cur_app, phase);
  modport master (output tick, req, input  green, yellow, red, cur_app, phase);
`endif

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin select: first pending approach after last, wrapping; last itself is lowest priority.
module rr_picker
  import traffic_pkg::*;
(
  input  logic [N_APP-1:0] pending,
  input  logic [APP_W-1:0] last,
  output logic             valid,
  output logic [APP_W-1:0] grant
);

  logic [APP_W-1:0] idx;

  always_comb begin
    valid = |pending;
    grant = last;
    idx   = '0;
    // scan farthest to nearest so the nearest pending approach after last wins
    for (int k = N_APP; k >= 1; k--) begin
      idx = last + APP_W'(k);
      if (pending[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated 4-approach phase scheduler (min/max green, yellow, all-red); PED_PHASE_EN adds a WALK phase.
// Lamps registered one cycle after the deciding tick; no backpressure: req is level-sampled, tick gates timers.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 5,
  parameter int ALL_RED_T = 2,
  parameter int WALK_T    = 8,
  parameter int CNT_W     = 7
) (
  input logic                      clk,
  input logic                      rst,
  traffic_phase_scheduler_if.slave bus
);

  phase_e           phase_q, phase_d;
  logic [APP_W-1:0] app_q, app_d, pick;
  logic [CNT_W-1:0] timer_q, timer_d, phase_last;
  logic [N_APP-1:0] pend_q, pend_d, other, hold_mask, grant_mask;
  logic [N_APP-1:0] lamp_g, lamp_y;
  logic             pick_vld, timer_done, ped_go, entering_green;

  rr_picker u_rr (
    .pending (pend_q),
    .last    (app_q),
    .valid   (pick_vld),
    .grant   (pick)
  );

`ifdef PED_PHASE_EN
  logic ped_q, ped_d;
  assign ped_go = ped_q;
`else
  assign ped_go = 1'b0;
`endif

  always_comb begin
    case (phase_q)
      YELLOW:  phase_last = CNT_W'(YELLOW_T - 1);
      ALL_RED: phase_last = CNT_W'(ALL_RED_T - 1);
      WALK:    phase_last = CNT_W'(WALK_T - 1);
      default: phase_last = CNT_W'(MAX_GREEN);
    endcase
  end

  assign timer_done = bus.tick && (timer_q == phase_last);
  assign other      = pend_q & ~app_onehot(app_q);

  always_comb begin
    phase_d = phase_q;
    app_d   = app_q;
    case (phase_q)
      IDLE: begin
        if (pick_vld) begin
          phase_d = GREEN;
          app_d   = pick;
        end
      end
      GREEN: begin
        // leave only for conflicting demand: gap-out when own detector idles, else max-out
        if (bus.tick && (timer_q >= CNT_W'(MIN_GREEN)) && (other != '0) &&
            (!bus.req[app_q] || (timer_q == CNT_W'(MAX_GREEN))))
          phase_d = YELLOW;
      end
      YELLOW: begin
        if (timer_done) phase_d = ALL_RED;
      end
      ALL_RED: begin
        if (timer_done) begin
          if (ped_go) begin
            phase_d = WALK;
          end else if (pick_vld) begin
            phase_d = GREEN;
            app_d   = pick;
          end else begin
            phase_d = IDLE;
          end
        end
      end
`ifdef PED_PHASE_EN
      WALK: begin
        if (timer_done) phase_d = ALL_RED;
      end
`endif
      default: phase_d = IDLE;
    endcase
  end

  assign entering_green = (phase_d == GREEN) && (phase_q != GREEN);
  assign hold_mask      = (phase_q == GREEN) ? app_onehot(app_q) : '0;
  assign grant_mask     = entering_green ? app_onehot(app_d) : '0;
  assign pend_d         = (pend_q | (bus.req & ~hold_mask)) & ~grant_mask;

  always_comb begin
    if ((phase_d != phase_q) || (phase_q == IDLE))
      timer_d = '0;
    else if (bus.tick && (timer_q != phase_last))
      timer_d = timer_q + CNT_W'(1);
    else
      timer_d = timer_q;
  end

  assign lamp_g = (phase_d == GREEN)  ? app_onehot(app_d) : '0;
  assign lamp_y = (phase_d == YELLOW) ? app_onehot(app_d) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q    <= IDLE;
      app_q      <= '0;
      timer_q    <= '0;
      pend_q     <= '0;
      bus.green  <= '0;
      bus.yellow <= '0;
      bus.red    <= '1;
    end else begin
      phase_q    <= phase_d;
      app_q      <= app_d;
      timer_q    <= timer_d;
      pend_q     <= pend_d;
      bus.green  <= lamp_g;
      bus.yellow <= lamp_y;
      bus.red    <= ~(lamp_g | lamp_y);
    end
  end

`ifdef PED_PHASE_EN
  assign ped_d = (ped_q | bus.ped_req) & ~((phase_d == WALK) && (phase_q != WALK));

  always_ff @(posedge clk) begin
    if (!rst) begin
      ped_q    <= 1'b0;
      bus.walk <= 1'b0;
    end else begin
      ped_q    <= ped_d;
      bus.walk <= (phase_d == WALK);
    end
  end
`endif

  assign bus.cur_app = app_q;
  assign bus.phase   = phase_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed vector table, hand sequences, and random traffic vs a phase-level model.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam int MIN_G   = 3;
  localparam int MAX_G   = 6;
  localparam int YEL_T   = 2;
  localparam int AR_T    = 1;
  localparam int WALK_TK = 8;
`ifdef PED_PHASE_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler #(
    .MIN_GREEN (MIN_G),
    .MAX_GREEN (MAX_G),
    .YELLOW_T  (YEL_T),
    .ALL_RED_T (AR_T),
    .WALK_T    (WALK_TK),
    .CNT_W     (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // phase-level reference: elapsed ticks per phase, pending demand as a bit set
  phase_e     m_ph   = IDLE;
  logic [1:0] m_app  = 2'd0;
  int         m_el   = 0;
  logic [3:0] m_pend = 4'h0;
  logic       m_ped  = 1'b0;

  function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
    for (int k = 1; k <= 4; k++)
      if (p[(int'(last) + k) % 4]) return 2'((int'(last) + k) % 4);
    return last;
  endfunction

  task automatic model_step(input logic r, input logic t, input logic [3:0] q, input logic pr);
    phase_e     nph;
    logic [1:0] napp;
    logic [3:0] own;
    if (!r) begin
      m_ph = IDLE; m_app = 2'd0; m_el = 0; m_pend = 4'h0; m_ped = 1'b0;
      return;
    end
    nph  = m_ph;
    napp = m_app;
    own  = 4'b0001 << m_app;
    case (m_ph)
      IDLE:    if (m_pend != 4'h0) begin nph = GREEN; napp = rr_pick(m_pend, m_app); end
      GREEN:   if (t && m_el >= MIN_G && (m_pend & ~own) != 4'h0 && (!q[m_app] || m_el == MAX_G)) nph = YELLOW;
      YELLOW:  if (t && m_el + 1 == YEL_T) nph = ALL_RED;
      ALL_RED: if (t && m_el + 1 == AR_T) begin
                 if (PED && m_ped) nph = WALK;
                 else if (m_pend != 4'h0) begin nph = GREEN; napp = rr_pick(m_pend, m_app); end
                 else nph = IDLE;
               end
      WALK:    if (t && m_el + 1 == WALK_TK) nph = ALL_RED;
      default: nph = IDLE;
    endcase
    m_pend = m_pend | (q & ((m_ph == GREEN) ? ~own : 4'hF));
    if (nph == GREEN && m_ph != GREEN) m_pend[napp] = 1'b0;
    m_ped = (m_ped | pr) && !(nph == WALK && m_ph != WALK);
    if (nph != m_ph) m_el = 0;
    else if (t) m_el = (m_ph == GREEN && m_el >= MAX_G) ? MAX_G : m_el + 1;
    m_ph  = nph;
    m_app = napp;
  endtask

  task automatic check_model();
    logic [3:0] eg, ey;
    logic       walk_ok;
    eg = (m_ph == GREEN)  ? (4'b0001 << m_app) : 4'h0;
    ey = (m_ph == YELLOW) ? (4'b0001 << m_app) : 4'h0;
    walk_ok = 1'b1;
`ifdef PED_PHASE_EN
    walk_ok = (bus.walk === (m_ph == WALK));
`endif
    total++;
    if (bus.green !== eg || bus.yellow !== ey || bus.red !== ~(eg | ey) ||
        bus.cur_app !== m_app || bus.phase !== m_ph || !walk_ok) begin
      bad++;
      $display("FAIL model cyc=%0d got ph=%0d g=%b y=%b r=%b app=%0d want ph=%0d g=%b y=%b r=%b app=%0d",
               cyc, bus.phase, bus.green, bus.yellow, bus.red, bus.cur_app,
               m_ph, eg, ey, ~(eg | ey), m_app);
    end
    total++;
    if ($countones(bus.green | bus.yellow) > 1) begin
      bad++;
      $display("FAIL lamp_onehot cyc=%0d got g=%b y=%b want at most one lit", cyc, bus.green, bus.yellow);
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] q, input logic t, input logic pr);
    rst      = r;
    bus.req  = q;
    bus.tick = t;
`ifdef PED_PHASE_EN
    bus.ped_req = pr;
`endif
    @(posedge clk);
    model_step(r, t, q, pr);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic expect_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    phase_e     ph;
    logic [3:0] g;
    logic [3:0] y;
    logic [1:0] app;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] q, input phase_e p,
                     input logic [3:0] g, input logic [3:0] y, input logic [1:0] a);
    vec_t v;
    v.rst = r; v.req = q; v.ph = p; v.g = g; v.y = y; v.app = a;
    vq.push_back(v);
  endtask

  initial begin
    int order[$];
    int durs[$];
    int dur;
    int n;
    logic [3:0] prev_g;
    int exp_order[5];

    bus.req  = 4'h0;
    bus.tick = 1'b0;
`ifdef PED_PHASE_EN
    bus.ped_req = 1'b0;
`endif

    // reset, single request, saturated rest, gap-out, timed gap-out, reset mid-yellow
    add(0, 4'h0, IDLE,    4'h0, 4'h0, 0);
    add(0, 4'h0, IDLE,    4'h0, 4'h0, 0);
    add(1, 4'h2, IDLE,    4'h0, 4'h0, 0);
    add(1, 4'h0, GREEN,   4'h2, 4'h0, 1);
    for (int i = 0; i < 5; i++) add(1, 4'h0, GREEN, 4'h2, 4'h0, 1);
    add(1, 4'h8, GREEN,   4'h2, 4'h0, 1);
    add(1, 4'h0, YELLOW,  4'h0, 4'h2, 1);
    add(1, 4'h0, YELLOW,  4'h0, 4'h2, 1);
    add(1, 4'h0, ALL_RED, 4'h0, 4'h0, 1);
    add(1, 4'h0, GREEN,   4'h8, 4'h0, 3);
    add(1, 4'h1, GREEN,   4'h8, 4'h0, 3);
    add(1, 4'h0, GREEN,   4'h8, 4'h0, 3);
    add(1, 4'h0, GREEN,   4'h8, 4'h0, 3);
    add(1, 4'h0, YELLOW,  4'h0, 4'h8, 3);
    add(1, 4'h4, YELLOW,  4'h0, 4'h8, 3);
    add(0, 4'h0, IDLE,    4'h0, 4'h0, 0);
    add(1, 4'h0, IDLE,    4'h0, 4'h0, 0);
    add(1, 4'h0, IDLE,    4'h0, 4'h0, 0);
    add(1, 4'h1, IDLE,    4'h0, 4'h0, 0);
    add(1, 4'h0, GREEN,   4'h1, 4'h0, 0);

    foreach (vq[i]) begin
      cycle(vq[i].rst, vq[i].req, 1'b1, 1'b0);
      total++;
      if (bus.phase !== vq[i].ph || bus.green !== vq[i].g || bus.yellow !== vq[i].y ||
          bus.red !== ~(vq[i].g | vq[i].y) || bus.cur_app !== vq[i].app) begin
        bad++;
        $display("FAIL vec%0d got ph=%0d g=%b y=%b r=%b app=%0d want ph=%0d g=%b y=%b app=%0d",
                 i, bus.phase, bus.green, bus.yellow, bus.red, bus.cur_app,
                 vq[i].ph, vq[i].g, vq[i].y, vq[i].app);
      end
    end

    // no conflicting demand: green rests indefinitely
    for (int i = 0; i < 55; i++) begin
      cycle(1'b1, 4'h0, 1'b1, 1'b0);
      expect_val("rest_green", int'(bus.green), 1);
    end

    // all four approaches held: round-robin with max-out each time
    exp_order = '{1, 2, 3, 0, 1};
    prev_g = bus.green;
    dur = 0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      cycle(1'b1, 4'hF, 1'b1, 1'b0);
      if (bus.green != 4'h0 && prev_g == 4'h0) begin
        order.push_back(int'(bus.cur_app));
        dur = 1;
      end else if (bus.green != 4'h0) begin
        dur++;
      end
      if (bus.green == 4'h0 && prev_g != 4'h0 && order.size() > 0) durs.push_back(dur);
      prev_g = bus.green;
    end
    expect_val("rr_grants_seen", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) expect_val("rr_order", order[i], exp_order[i]);
    for (int i = 0; i < 4 && i < durs.size(); i++) expect_val("maxout_len", durs[i], MAX_G + 1);

    // random traffic, sparse resets, gappy tick
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] q;
      for (int b = 0; b < 4; b++) q[b] = ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 299) != 0, q, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

`ifdef PED_PHASE_EN
    // pedestrian call during green on 0 with approach 2 waiting
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'h1, 1'b1, 1'b0);
    cycle(1'b1, 4'h0, 1'b1, 1'b0);
    expect_val("ped_green0", int'(bus.green), 1);
    cycle(1'b1, 4'h4, 1'b1, 1'b1);
    n = 0;
    while (bus.walk !== 1'b1 && n < 60) begin
      cycle(1'b1, 4'h0, 1'b1, 1'b0);
      n++;
    end
    expect_val("walk_reached", int'(bus.walk === 1'b1), 1);
    n = 0;
    while (bus.walk === 1'b1 && n < 60) begin
      n++;
      cycle(1'b1, 4'h0, 1'b1, 1'b0);
    end
    expect_val("walk_len", n, WALK_TK);
    expect_val("post_walk_allred", int'(bus.phase), int'(ALL_RED));
    cycle(1'b1, 4'h0, 1'b1, 1'b0);
    expect_val("post_walk_green", int'(bus.green), 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got no completion want finish", cyc);
    $fatal(1);
  end

endmodule
